uart_cfg_ctrl: RTL and testbench

- Command sequencer behind the UART frame receiver in the BTLE design.
- Consumes received bytes (`rx_frame`/`rx_done`/`frame_error`) and assembles fixed-format configuration packets: SYNC, ADDR, DATA_BYTES data bytes, CHK.
- Validates each packet, then issues one register-write transaction to the BTLE configuration register file over a req/ack handshake.
- Handles packet abort on UART frame error, checksum mismatch and inter-byte timeout.

---
 rtl/uart_cfg_ctrl_if.sv | 14 +
 rtl/uart_cfg_ctrl.sv | 146 ++++++++++++++
 tb/tb_uart_cfg_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cfg_ctrl_if.sv
// Register-write bus between the config sequencer (master) and the register file (slave).
// The master holds req/addr/wdata until the slave returns a one-cycle ack.
interface uart_cfg_ctrl_if #(
  parameter int ADDR_WD    = 8,
  parameter int DATA_BYTES = 2
) ();
  logic                    reg_wr_req;
  logic [ADDR_WD-1:0]      reg_addr;
  logic [8*DATA_BYTES-1:0] reg_wdata;
  logic                    reg_wr_ack;

  modport master (output reg_wr_req, output reg_addr, output reg_wdata, input reg_wr_ack);
  modport slave  (input reg_wr_req, input reg_addr, input reg_wdata, output reg_wr_ack);
endinterface

// File: rtl/uart_cfg_ctrl.sv
// Packet sequencer: SYNC, ADDR, data bytes, XOR checksum -> one register write; all outputs 1 cycle after the causing event.
// Bytes arriving while a write waits for ack are dropped and flagged; there is no upstream backpressure.
module uart_cfg_ctrl #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         ADDR_WD     = 8,
  parameter int         DATA_BYTES  = 2,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          rx_frame,
  input  logic                rx_done,
  input  logic                frame_error,
  uart_cfg_ctrl_if.master     reg_bus,
  output logic                busy,
  output logic                err_chk,
  output logic                err_frame,
  output logic                err_timeout,
  output logic                err_ovr,
  output logic [7:0]          pkt_cnt
);

  localparam int              TO_WD    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_WD-1:0] TO_LAST = TO_WD'(TIMEOUT_CYC - 1);
  localparam logic [2:0]      LAST_IDX = 3'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    CHK,
    WRITE
  } state_t;

  state_t                  state;
  logic [2:0]              byte_idx;
  logic [7:0]              chk_acc;
  logic [TO_WD-1:0]        to_cnt;
  logic                    wr_req_q;
  logic [ADDR_WD-1:0]      addr_q;
  logic [8*DATA_BYTES-1:0] wdata_q;

  assign reg_bus.reg_wr_req = wr_req_q;
  assign reg_bus.reg_addr   = addr_q;
  assign reg_bus.reg_wdata  = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      byte_idx    <= '0;
      chk_acc     <= '0;
      to_cnt      <= '0;
      wr_req_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy        <= 1'b0;
      err_chk     <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      err_ovr     <= 1'b0;
      pkt_cnt     <= '0;
    end else begin
      err_chk     <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      err_ovr     <= 1'b0;

      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (rx_done && !frame_error && rx_frame == SYNC_BYTE) begin
            state <= ADDR;
            busy  <= 1'b1;
          end
        end

        ADDR, DATA, CHK: begin
          if (rx_done) begin
            // A byte in the threshold cycle still counts as on time.
            to_cnt <= '0;
            if (frame_error) begin
              state     <= IDLE;
              busy      <= 1'b0;
              err_frame <= 1'b1;
            end else begin
              case (state)
                ADDR: begin
                  addr_q   <= rx_frame[ADDR_WD-1:0];
                  chk_acc  <= rx_frame;
                  byte_idx <= '0;
                  state    <= DATA;
                end
                DATA: begin
                  wdata_q[8*byte_idx +: 8] <= rx_frame;
                  chk_acc  <= chk_acc ^ rx_frame;
                  byte_idx <= byte_idx + 3'd1;
                  if (byte_idx == LAST_IDX) begin
                    state <= CHK;
                  end
                end
                default: begin
                  if (rx_frame == chk_acc) begin
                    state    <= WRITE;
                    wr_req_q <= 1'b1;
                  end else begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    err_chk <= 1'b1;
                  end
                end
              endcase
            end
          end else if (to_cnt == TO_LAST) begin
            state       <= IDLE;
            busy        <= 1'b0;
            err_timeout <= 1'b1;
            to_cnt      <= '0;
          end else begin
            to_cnt <= to_cnt + TO_WD'(1);
          end
        end

        WRITE: begin
          // Address and data stay frozen; nothing aborts a pending write except reset.
          to_cnt <= '0;
          if (rx_done) begin
            err_ovr <= 1'b1;
          end
          if (reg_bus.reg_wr_ack) begin
            state    <= IDLE;
            busy     <= 1'b0;
            wr_req_q <= 1'b0;
            pkt_cnt  <= pkt_cnt + 8'd1;
          end
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          wr_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Bench for uart_cfg_ctrl: directed scenarios plus randomized packets against a queue-based packet model.
module tb_uart_cfg_ctrl;

  localparam int         DB   = 2;
  localparam int         TO   = 20;
  localparam int         AW   = 8;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    rx_frame = 8'h00;
  logic          rx_done = 1'b0;
  logic          frame_error = 1'b0;
  logic          busy, err_chk, err_frame, err_timeout, err_ovr;
  logic [7:0]    pkt_cnt;

  uart_cfg_ctrl_if #(.ADDR_WD(AW), .DATA_BYTES(DB)) bus ();

  uart_cfg_ctrl #(
    .SYNC_BYTE(SYNC), .ADDR_WD(AW), .DATA_BYTES(DB), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_frame(rx_frame), .rx_done(rx_done),
    .frame_error(frame_error), .reg_bus(bus.master), .busy(busy),
    .err_chk(err_chk), .err_frame(err_frame), .err_timeout(err_timeout),
    .err_ovr(err_ovr), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit ack_rand = 1'b0;

  // Reference model: a packet is the byte list after SYNC; its meaning follows from its length.
  int                m_mode;   // 0 hunting, 1 collecting, 2 writing
  logic [7:0]        m_pkt[$];
  int                m_gap;
  logic              m_req, m_busy, m_echk, m_efrm, m_eto, m_eovr;
  logic [AW-1:0]     m_addr;
  logic [8*DB-1:0]   m_data;
  logic [7:0]        m_cnt;
  int n_chk = 0, n_frm = 0, n_to = 0, n_ovr = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_pkt.delete(); m_gap = 0;
      m_req = 0; m_busy = 0; m_echk = 0; m_efrm = 0; m_eto = 0; m_eovr = 0;
      m_addr = '0; m_data = '0; m_cnt = 8'd0;
    end else begin
      m_echk = 0; m_efrm = 0; m_eto = 0; m_eovr = 0;
      if (m_mode == 2) begin
        if (rx_done) begin m_eovr = 1; n_ovr++; end
        if (bus.reg_wr_ack) begin m_mode = 0; m_cnt = m_cnt + 8'd1; end
      end else if (m_mode == 1) begin
        if (rx_done && frame_error) begin
          m_mode = 0; m_efrm = 1; n_frm++;
        end else if (rx_done) begin
          m_gap = 0;
          m_pkt.push_back(rx_frame);
          if (m_pkt.size() == DB + 2) begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 0; i <= DB; i++) x = x ^ m_pkt[i];
            if (m_pkt[DB+1] == x) begin
              m_mode = 2;
              m_addr = m_pkt[0][AW-1:0];
              for (int k = 0; k < DB; k++) m_data[8*k +: 8] = m_pkt[1+k];
            end else begin
              m_mode = 0; m_echk = 1; n_chk++;
            end
          end
        end else begin
          m_gap++;
          if (m_gap == TO) begin m_mode = 0; m_eto = 1; n_to++; end
        end
      end else if (rx_done && !frame_error && rx_frame == SYNC) begin
        m_mode = 1; m_pkt.delete(); m_gap = 0;
      end
      m_req  = (m_mode == 2);
      m_busy = (m_mode != 0);
    end
  end

  // Tallies of cycles where the DUT departs from the model, and of observed pulses.
  int div_cnt = 0;
  int o_chk = 0, o_frm = 0, o_to = 0, o_ovr = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.reg_wr_req !== m_req || busy !== m_busy || err_chk !== m_echk ||
          err_frame !== m_efrm || err_timeout !== m_eto || err_ovr !== m_eovr ||
          pkt_cnt !== m_cnt ||
          (m_req && (bus.reg_addr !== m_addr || bus.reg_wdata !== m_data)))
        div_cnt++;
      o_chk += int'(err_chk === 1'b1);
      o_frm += int'(err_frame === 1'b1);
      o_to  += int'(err_timeout === 1'b1);
      o_ovr += int'(err_ovr === 1'b1);
    end
  end

  logic [7:0] seq[$];

  task automatic tick(input logic rd, input logic [7:0] b, input logic fe);
    @(negedge clk);
    rx_done = rd; rx_frame = b; frame_error = fe;
    if (ack_rand) bus.reg_wr_ack = ($urandom_range(0, 3) == 0);
  endtask

  task automatic send_seq(input int gap);
    foreach (seq[i]) begin
      tick(1'b1, seq[i], 1'b0);
      repeat (gap) tick(1'b0, 8'h00, 1'b0);
    end
    tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_req(input int max_cyc);
    int n = 0;
    while (bus.reg_wr_req !== 1'b1 && n < max_cyc) begin
      tick(1'b0, 8'h00, 1'b0);
      n++;
    end
  endtask

  task automatic do_ack();
    tick(1'b0, 8'h00, 1'b0);
    bus.reg_wr_ack = 1'b1;
    tick(1'b0, 8'h00, 1'b0);
    bus.reg_wr_ack = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #20;
    checks++; if (bus.reg_wr_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.reg_wr_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({err_chk, err_frame, err_timeout, err_ovr} !== 4'b0000) begin
      errors++; $display("FAIL reset_err got %b want 0000", {err_chk, err_frame, err_timeout, err_ovr}); end
    checks++; if (pkt_cnt !== 8'd0) begin errors++; $display("FAIL reset_pkt_cnt got %0d want 0", pkt_cnt); end
    checks++; if (bus.reg_addr !== '0 || bus.reg_wdata !== '0) begin
      errors++; $display("FAIL reset_bus got %h/%h want 0/0", bus.reg_addr, bus.reg_wdata); end
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_valid_write();
    int d0 = div_cnt;
    int e0 = o_chk + o_frm + o_to + o_ovr;
    seq = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h70};
    send_seq(1);
    wait_req(10);
    checks++; if (bus.reg_wr_req !== 1'b1) begin errors++; $display("FAIL valid_req got %b want 1", bus.reg_wr_req); end
    checks++; if (bus.reg_addr !== 8'h12) begin errors++; $display("FAIL valid_addr got %h want 12", bus.reg_addr); end
    checks++; if (bus.reg_wdata !== 16'h5634) begin errors++; $display("FAIL valid_data got %h want 5634", bus.reg_wdata); end
    repeat (2) tick(1'b0, 8'h00, 1'b0);
    checks++; if (bus.reg_wr_req !== 1'b1) begin errors++; $display("FAIL valid_req_held got %b want 1", bus.reg_wr_req); end
    do_ack();
    checks++; if (bus.reg_wr_req !== 1'b0) begin errors++; $display("FAIL valid_req_drop got %b want 0", bus.reg_wr_req); end
    checks++; if (pkt_cnt !== 8'd1) begin errors++; $display("FAIL valid_pkt_cnt got %0d want 1", pkt_cnt); end
    checks++; if (o_chk + o_frm + o_to + o_ovr !== e0) begin
      errors++; $display("FAIL valid_no_err got %0d pulses want 0", o_chk + o_frm + o_to + o_ovr - e0); end
    checks++; if (div_cnt !== d0) begin errors++; $display("FAIL valid_track divergences %0d want 0", div_cnt - d0); end
  endtask

  task automatic test_bad_chk();
    int d0 = div_cnt;
    int c0 = o_chk;
    seq = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h71};
    send_seq(0);
    repeat (4) tick(1'b0, 8'h00, 1'b0);
    checks++; if (o_chk - c0 !== 1) begin errors++; $display("FAIL badchk_pulse got %0d want 1", o_chk - c0); end
    checks++; if (busy !== 1'b0 || bus.reg_wr_req !== 1'b0) begin
      errors++; $display("FAIL badchk_idle got busy=%b req=%b want 0/0", busy, bus.reg_wr_req); end
    checks++; if (pkt_cnt !== 8'd1) begin errors++; $display("FAIL badchk_pkt_cnt got %0d want 1", pkt_cnt); end
    checks++; if (div_cnt !== d0) begin errors++; $display("FAIL badchk_track divergences %0d want 0", div_cnt - d0); end
  endtask

  task automatic test_timeout();
    int d0 = div_cnt;
    int t0 = o_to;
    int n = 0;
    tick(1'b1, 8'hA5, 1'b0);
    tick(1'b1, 8'h12, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    n = 1;
    while (err_timeout !== 1'b1 && n < 3 * TO) begin
      tick(1'b0, 8'h00, 1'b0);
      n++;
    end
    checks++; if (n !== TO + 1) begin errors++; $display("FAIL timeout_latency got %0d want %0d", n, TO + 1); end
    tick(1'b0, 8'h00, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle got busy=%b want 0", busy); end
    // Every gap lands the next byte exactly on the threshold cycle: no abort.
    seq = '{8'hA5, 8'h01, 8'hFF, 8'h00, 8'hFE};
    send_seq(TO - 1);
    wait_req(5);
    checks++; if (bus.reg_wr_req !== 1'b1 || bus.reg_addr !== 8'h01 || bus.reg_wdata !== 16'h00FF) begin
      errors++; $display("FAIL timeout_edge_write got req=%b %h/%h want 1 01/00ff", bus.reg_wr_req, bus.reg_addr, bus.reg_wdata); end
    do_ack();
    checks++; if (o_to - t0 !== 1) begin errors++; $display("FAIL timeout_count got %0d want 1", o_to - t0); end
    checks++; if (pkt_cnt !== 8'd2) begin errors++; $display("FAIL timeout_pkt_cnt got %0d want 2", pkt_cnt); end
    checks++; if (div_cnt !== d0) begin errors++; $display("FAIL timeout_track divergences %0d want 0", div_cnt - d0); end
  endtask

  task automatic test_frame_err();
    int d0 = div_cnt;
    int f0 = o_frm;
    int e0 = o_chk + o_to + o_ovr;
    tick(1'b1, 8'hA5, 1'b0);
    tick(1'b1, 8'h12, 1'b0);
    tick(1'b1, 8'h34, 1'b1);
    tick(1'b1, 8'h56, 1'b0);
    tick(1'b1, 8'h70, 1'b0);
    repeat (4) tick(1'b0, 8'h00, 1'b0);
    checks++; if (o_frm - f0 !== 1) begin errors++; $display("FAIL frame_pulse got %0d want 1", o_frm - f0); end
    checks++; if (o_chk + o_to + o_ovr !== e0) begin
      errors++; $display("FAIL frame_other_err got %0d want 0", o_chk + o_to + o_ovr - e0); end
    checks++; if (busy !== 1'b0 || bus.reg_wr_req !== 1'b0 || pkt_cnt !== 8'd2) begin
      errors++; $display("FAIL frame_idle got busy=%b req=%b cnt=%0d want 0/0/2", busy, bus.reg_wr_req, pkt_cnt); end
    checks++; if (div_cnt !== d0) begin errors++; $display("FAIL frame_track divergences %0d want 0", div_cnt - d0); end
  endtask

  task automatic test_overrun();
    int d0 = div_cnt;
    int v0 = o_ovr;
    int bad = 0;
    seq = '{8'hA5, 8'h3C, 8'hAA, 8'h55, 8'hC3};
    send_seq(0);
    wait_req(5);
    for (int i = 0; i < 100; i++) begin
      if (i == 10) tick(1'b1, 8'hA5, 1'b0);
      else tick(1'b0, 8'h00, 1'b0);
      if (bus.reg_wr_req !== 1'b1 || bus.reg_addr !== 8'h3C || bus.reg_wdata !== 16'h55AA) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL ovr_stable got %0d unstable cycles want 0", bad); end
    checks++; if (o_ovr - v0 !== 1) begin errors++; $display("FAIL ovr_pulse got %0d want 1", o_ovr - v0); end
    do_ack();
    repeat (2) tick(1'b0, 8'h00, 1'b0);
    checks++; if (pkt_cnt !== 8'd3 || bus.reg_wr_req !== 1'b0) begin
      errors++; $display("FAIL ovr_single_write got cnt=%0d req=%b want 3/0", pkt_cnt, bus.reg_wr_req); end
    checks++; if (div_cnt !== d0) begin errors++; $display("FAIL ovr_track divergences %0d want 0", div_cnt - d0); end
  endtask

  task automatic test_garbage();
    int d0 = div_cnt;
    int e0 = o_chk + o_frm + o_to + o_ovr;
    seq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h77, 8'h01, 8'h02, 8'h74};
    send_seq(0);
    wait_req(5);
    checks++; if (bus.reg_wr_req !== 1'b1 || bus.reg_addr !== 8'h77 || bus.reg_wdata !== 16'h0201) begin
      errors++; $display("FAIL garbage_write got req=%b %h/%h want 1 77/0201", bus.reg_wr_req, bus.reg_addr, bus.reg_wdata); end
    do_ack();
    checks++; if (o_chk + o_frm + o_to + o_ovr !== e0 || pkt_cnt !== 8'd4) begin
      errors++; $display("FAIL garbage_silent got pulses=%0d cnt=%0d want 0/4", o_chk + o_frm + o_to + o_ovr - e0, pkt_cnt); end
    checks++; if (div_cnt !== d0) begin errors++; $display("FAIL garbage_track divergences %0d want 0", div_cnt - d0); end
  endtask

  task automatic test_random();
    int d0 = div_cnt;
    ack_rand = 1'b1;
    for (int p = 0; p < 60; p++) begin
      int kind = $urandom_range(0, 3);
      logic [7:0] x = 8'h00;
      seq.delete();
      if (kind == 3) begin
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) seq.push_back(8'($urandom));
      end else begin
        seq.push_back(SYNC);
        for (int j = 0; j <= DB; j++) begin
          logic [7:0] b = 8'($urandom);
          seq.push_back(b);
          x = x ^ b;
        end
        if (kind == 2) x = x ^ (8'h01 << $urandom_range(0, 7));
        seq.push_back(x);
      end
      foreach (seq[i]) begin
        int gap = ($urandom_range(0, 11) == 0) ? TO - 2 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
        tick(1'b1, seq[i], $urandom_range(0, 24) == 0);
        repeat (gap) tick(1'b0, 8'h00, 1'b0);
      end
      repeat ($urandom_range(0, 6)) tick(1'b0, 8'h00, 1'b0);
    end
    ack_rand = 1'b0;
    tick(1'b0, 8'h00, 1'b0);
    bus.reg_wr_ack = 1'b1;
    repeat (TO + 4) tick(1'b0, 8'h00, 1'b0);
    bus.reg_wr_ack = 1'b0;
    tick(1'b0, 8'h00, 1'b0);
    checks++; if (div_cnt !== d0) begin errors++; $display("FAIL random_track divergences %0d want 0", div_cnt - d0); end
    checks++; if (o_chk !== n_chk || o_frm !== n_frm || o_to !== n_to || o_ovr !== n_ovr) begin
      errors++; $display("FAIL random_pulses got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                         o_chk, o_frm, o_to, o_ovr, n_chk, n_frm, n_to, n_ovr); end
    checks++; if (pkt_cnt !== m_cnt) begin errors++; $display("FAIL random_pkt_cnt got %0d want %0d", pkt_cnt, m_cnt); end
  endtask

  task automatic test_reset_mid_write();
    seq = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h00};
    send_seq(0);
    wait_req(5);
    checks++; if (bus.reg_wr_req !== 1'b1) begin errors++; $display("FAIL rstw_req_before got %b want 1", bus.reg_wr_req); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus.reg_wr_req !== 1'b0 || busy !== 1'b0 || pkt_cnt !== 8'd0) begin
      errors++; $display("FAIL rstw_immediate got req=%b busy=%b cnt=%0d want 0/0/0", bus.reg_wr_req, busy, pkt_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick(1'b0, 8'h00, 1'b0);
    checks++; if (bus.reg_wr_req !== 1'b0 || pkt_cnt !== 8'd0) begin
      errors++; $display("FAIL rstw_after got req=%b cnt=%0d want 0/0", bus.reg_wr_req, pkt_cnt); end
  endtask

  initial begin
    bus.reg_wr_ack = 1'b0;
    test_reset();
    test_valid_write();
    test_bad_chk();
    test_timeout();
    test_frame_err();
    test_overrun();
    test_garbage();
    test_random();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
